keypad_frontend: RTL and testbench

Front end for the digital lock's 4-key keypad. It synchronizes and debounces the raw key lines and rejects multi-key presses. Each accepted press is delivered as a one-hot key word over a valid/ready handshake. Its output is the one-hot key bus that feeds the lock's 4-to-2 key encoder and PIN shift register, and it supplies the clean per-press strobe that the encoder side cannot generate itself.

---
 rtl/keypad_frontend.sv | 231 +++++++++++++++++++++++
 tb/tb_keypad_frontend.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_frontend.sv
// ---------------------------------------------------------------------------
// keypad_frontend
//
// Front end for the digital lock's 4-key keypad. The raw key lines are
// synchronized and debounced, and presses of more than one key at a time are
// rejected. Each accepted press is delivered as a one-hot key word over a
// valid/ready handshake. This word feeds the lock's key encoder and PIN shift
// register. The key_valid rise acts as the per-press strobe.
//
// Parameters:
//   DEBOUNCE_CYCLES : stable synchronized cycles needed to accept a press or
//                     a release (>= 2)
//   REPEAT_CYCLES   : held cycles between auto-repeat events (repeat build only)
//   CNT_W           : width of the debounce and repeat counters
//
// Ports:
//   clk           in   clock
//   reset         in   asynchronous, active-high reset
//   raw_keys      in   [3:0] raw key lines, asynchronous, active-high
//   key_onehot    out  [3:0] pending key, one-hot; 0 when nothing is pending
//   key_valid     out  key_onehot holds a pending key
//   key_ready     in   consumer accepts the pending key
//   multi_key_err out  one-cycle pulse: stable multi-key pattern rejected
//   overrun       out  one-cycle pulse: key event dropped, key still pending
//   key_held      out  an accepted key is currently held down
//
// Optional feature:
//   KEYPAD_REPEAT_EN : when defined, a key held in PRESSED raises a new key
//                      event every REPEAT_CYCLES cycles after the first one.
// ---------------------------------------------------------------------------
module keypad_frontend #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 16,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] raw_keys,
  output logic [3:0] key_onehot,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       multi_key_err,
  output logic       overrun,
  output logic       key_held
);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_e;

  // The counter holds the number of stable cycles already seen. The last
  // stable cycle is therefore recognised when the counter equals N-1.
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // This block is elaborated only for an illegal parameter set. It makes the
  // bad configuration visible in the elaborated hierarchy.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1 || CNT_W < 2) begin : gParamRangeViolation
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       keySync1_q, keyS_q;
  logic [3:0]       keyOnehot_q, keyOnehot_d;
  logic             keyValid_q, keyValid_d;
  logic             multiErr_q, multiErr_d;
  logic             overrun_q, overrun_d;
  logic             keyHeld_q, keyHeld_d;
  logic             keyEvent;
  logic             candOneHot;

`ifdef KEYPAD_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] rep_q, rep_d;
`endif

  // The raw key lines are asynchronous. Only keyS_q, the output of the
  // second flop, is safe for the FSM to look at.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      keySync1_q <= 4'd0;
      keyS_q     <= 4'd0;
    end else begin
      keySync1_q <= raw_keys;
      keyS_q     <= keySync1_q;
    end
  end

  // A candidate is acceptable only when exactly one bit is set.
  assign candOneHot = (cand_q != 4'd0) && ((cand_q & (cand_q - 4'd1)) == 4'd0);

  // Debounce FSM. It decides when a stable press becomes a key event or a
  // multi-key rejection. It also waits for a full release before arming again.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cand_d     = cand_q;
    keyEvent   = 1'b0;
    multiErr_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d      = rep_q;
`endif
    case (state_q)
      IDLE: begin
        if (keyS_q != 4'd0) begin
          cand_d  = keyS_q;
          cnt_d   = CNT_W'(1);
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (keyS_q != cand_q) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == DEB_LAST) begin
          cnt_d = '0;
          if (candOneHot) begin
            keyEvent = 1'b1;
            state_d  = PRESSED;
          end else begin
            multiErr_d = 1'b1;
            state_d    = RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (keyS_q == 4'd0) begin
          // This cycle already counts as the first released cycle.
          cnt_d   = CNT_W'(1);
          state_d = RELEASE;
        end
`ifdef KEYPAD_REPEAT_EN
        else if (keyS_q == cand_q) begin
          if (rep_q == REP_LAST) begin
            keyEvent = 1'b1;
            rep_d    = '0;
          end else begin
            rep_d = rep_q + CNT_W'(1);
          end
        end
`endif
      end
      RELEASE: begin
        if (keyS_q != 4'd0) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
`ifdef KEYPAD_REPEAT_EN
    if (state_d != PRESSED) begin
      rep_d = '0;
    end
`endif
  end

  // Output handshake. A key event that arrives on the same edge as an
  // acceptance replaces the consumed key. A key event that arrives while a
  // key is still pending is dropped and flagged.
  always_comb begin
    keyOnehot_d = keyOnehot_q;
    keyValid_d  = keyValid_q;
    overrun_d   = 1'b0;
    if (keyEvent) begin
      if (!keyValid_q || key_ready) begin
        keyOnehot_d = cand_q;
        keyValid_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (keyValid_q && key_ready) begin
      keyOnehot_d = 4'd0;
      keyValid_d  = 1'b0;
    end
    keyHeld_d = (state_d == PRESSED);
  end

  // State and output registers. Every output comes directly from a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cand_q      <= 4'd0;
      keyOnehot_q <= 4'd0;
      keyValid_q  <= 1'b0;
      multiErr_q  <= 1'b0;
      overrun_q   <= 1'b0;
      keyHeld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      keyOnehot_q <= keyOnehot_d;
      keyValid_q  <= keyValid_d;
      multiErr_q  <= multiErr_d;
      overrun_q   <= overrun_d;
      keyHeld_q   <= keyHeld_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  // The repeat counter is cleared whenever the FSM leaves PRESSED.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`endif

  assign key_onehot    = keyOnehot_q;
  assign key_valid     = keyValid_q;
  assign multi_key_err = multiErr_q;
  assign overrun       = overrun_q;
  assign key_held      = keyHeld_q;

endmodule

// File: tb/tb_keypad_frontend.sv
// ---------------------------------------------------------------------------
// tb_keypad_frontend
//
// Directed testbench for keypad_frontend. A behavioural model tracks the run
// length of the synchronized key value, an armed/held flag pair, and the
// pending-key handshake. A compare process checks every DUT output against
// this model on each falling edge. Hand-computed literal checks pin the
// expected press latency and the expected pulse counts.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_keypad_frontend;

  localparam int DEB = 4;
  localparam int REP = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] raw_keys = 4'd0;
  logic       key_ready = 1'b0;
  logic [3:0] key_onehot;
  logic       key_valid;
  logic       multi_key_err;
  logic       overrun;
  logic       key_held;

  keypad_frontend #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_CYCLES  (REP),
    .CNT_W          (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .raw_keys     (raw_keys),
    .key_onehot   (key_onehot),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .multi_key_err(multi_key_err),
    .overrun      (overrun),
    .key_held     (key_held)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit checkEn = 1'b0;
  int validRises = 0;
  int ovrPulses = 0;
  int errPulses = 0;
  logic prevValid = 1'b0;

  // Model state. The model predicts outputs from the history of the
  // synchronized key value: how long that value has been stable, whether a
  // new press may be accepted (armed), and whether an accepted key is held.
  logic [3:0] mS1 = 4'd0, mS2 = 4'd0, lastVal = 4'd0, mCand = 4'd0;
  int         run = 0;
  int         rep = 0;
  bit         armed = 1'b1, held = 1'b0;
  logic [3:0] mOnehot = 4'd0;
  bit         mValid = 1'b0, mErr = 1'b0, mOvr = 1'b0;

  // Model update on each clock edge. It uses the inputs as they were just
  // before the edge.
  always @(posedge clk or posedge reset) begin
    bit ev;
    logic [3:0] s;
    if (reset) begin
      mS1 = 4'd0; mS2 = 4'd0; lastVal = 4'd0; mCand = 4'd0;
      run = 0; rep = 0; armed = 1'b1; held = 1'b0;
      mOnehot = 4'd0; mValid = 1'b0; mErr = 1'b0; mOvr = 1'b0;
    end else begin
      ev = 1'b0;
      mErr = 1'b0;
      s = mS2;
      if (s == lastVal) begin
        if (run < 100000) run++;
      end else begin
        run = 1;
      end
      lastVal = s;
      if (held) begin
        if (s == 4'd0) begin
          held = 1'b0;
          rep = 0;
        end
`ifdef KEYPAD_REPEAT_EN
        else if (s == mCand) begin
          rep++;
          if (rep == REP) begin
            ev = 1'b1;
            rep = 0;
          end
        end
`endif
      end else if (armed) begin
        if (s != 4'd0 && run == DEB) begin
          armed = 1'b0;
          if ($countones(s) == 1) begin
            ev = 1'b1;
            held = 1'b1;
            mCand = s;
            rep = 0;
          end else begin
            mErr = 1'b1;
          end
        end
      end else if (s == 4'd0 && run == DEB) begin
        armed = 1'b1;
      end
      mOvr = 1'b0;
      if (ev) begin
        if (!mValid || key_ready) begin
          mOnehot = mCand;
          mValid = 1'b1;
        end else begin
          mOvr = 1'b1;
        end
      end else if (mValid && key_ready) begin
        mValid = 1'b0;
        mOnehot = 4'd0;
      end
      mS2 = mS1;
      mS1 = raw_keys;
    end
  end

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process and event counters. These run on the falling edge,
  // away from the active edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("key_onehot", key_onehot, mOnehot);
      checkOutput("key_valid", {3'd0, key_valid}, {3'd0, mValid});
      checkOutput("multi_key_err", {3'd0, multi_key_err}, {3'd0, mErr});
      checkOutput("overrun", {3'd0, overrun}, {3'd0, mOvr});
      checkOutput("key_held", {3'd0, key_held}, {3'd0, held});
      if (key_valid && !prevValid) validRises++;
      if (overrun) ovrPulses++;
      if (multi_key_err) errPulses++;
    end
    prevValid = key_valid;
  end

  // Called at a falling edge: drives the inputs for `cycles` rising edges.
  task automatic applyStimulus(input logic [3:0] raw, input logic ready, input int cycles);
    raw_keys = raw;
    key_ready = ready;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    int vr0, ov0, er0;
    int expRepeat;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkEn = 1'b1;
    checkOutput("reset_valid", {3'd0, key_valid}, 4'd0);
    checkOutput("reset_onehot", key_onehot, 4'd0);
    applyStimulus(4'd0, 1'b0, 3);

    // Clean press: key_valid must rise on edge 6.
    raw_keys = 4'b0100;
    key_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 checkOutput("press_edge5_valid", {3'd0, key_valid}, 4'd0);
    @(posedge clk);
    #1 checkOutput("press_edge6_valid", {3'd0, key_valid}, 4'd1);
    checkOutput("press_edge6_onehot", key_onehot, 4'b0100);
    @(negedge clk);
    applyStimulus(4'b0100, 1'b0, 14);
    checkOutput("press_held", {3'd0, key_held}, 4'd1);
    applyStimulus(4'b0100, 1'b1, 1);
    checkOutput("accept_valid", {3'd0, key_valid}, 4'd0);
    checkOutput("accept_onehot", key_onehot, 4'd0);
    applyStimulus(4'd0, 1'b0, 10);

    // Bounce: a press that is too short produces no output.
    vr0 = validRises; er0 = errPulses;
    applyStimulus(4'b0001, 1'b0, 3);
    applyStimulus(4'd0, 1'b0, 10);
    checkOutput("bounce_no_valid", 4'(validRises - vr0), 4'd0);
    checkOutput("bounce_no_err", 4'(errPulses - er0), 4'd0);

    // Multi-key pattern, followed by a clean press of 1000.
    vr0 = validRises; er0 = errPulses;
    applyStimulus(4'b0011, 1'b0, 10);
    checkOutput("multi_err_count", 4'(errPulses - er0), 4'd1);
    checkOutput("multi_no_valid", 4'(validRises - vr0), 4'd0);
    applyStimulus(4'd0, 1'b0, 10);
    applyStimulus(4'b1000, 1'b0, 10);
    checkOutput("after_multi_onehot", key_onehot, 4'b1000);
    applyStimulus(4'b1000, 1'b1, 1);
    applyStimulus(4'd0, 1'b0, 10);

    // Overrun: the second press is dropped while 0001 is still pending.
    vr0 = validRises; ov0 = ovrPulses;
    applyStimulus(4'b0001, 1'b0, 10);
    applyStimulus(4'd0, 1'b0, 10);
    applyStimulus(4'b1000, 1'b0, 10);
    applyStimulus(4'd0, 1'b0, 10);
    checkOutput("overrun_count", 4'(ovrPulses - ov0), 4'd1);
    checkOutput("overrun_keeps_key", key_onehot, 4'b0001);
    applyStimulus(4'd0, 1'b1, 1);
    checkOutput("overrun_drained", {3'd0, key_valid}, 4'd0);
    applyStimulus(4'd0, 1'b0, 5);
    checkOutput("overrun_one_delivery", 4'(validRises - vr0), 4'd1);

    // Reset pulsed around edge 4 while 0010 is being debounced.
    raw_keys = 4'b0010;
    key_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 checkOutput("midreset_valid", {3'd0, key_valid}, 4'd0);
    checkOutput("midreset_held", {3'd0, key_held}, 4'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1 checkOutput("postreset_edge5", {3'd0, key_valid}, 4'd0);
    @(posedge clk);
    #1 checkOutput("postreset_edge6", key_onehot, 4'b0010);
    @(negedge clk);
    applyStimulus(4'b0010, 1'b1, 1);
    applyStimulus(4'd0, 1'b0, 10);

    // Auto-repeat, or a single event when the feature is not built.
`ifdef KEYPAD_REPEAT_EN
    expRepeat = 3;
`else
    expRepeat = 1;
`endif
    vr0 = validRises; ov0 = ovrPulses;
    applyStimulus(4'b0010, 1'b1, 46);
    applyStimulus(4'd0, 1'b1, 10);
    checkOutput("repeat_events", 4'(validRises - vr0), 4'(expRepeat));
    checkOutput("repeat_no_overrun", 4'(ovrPulses - ov0), 4'd0);

    applyStimulus(4'd0, 1'b0, 4);
    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
